// File: rtl/fetch_sequencer_pkg.sv
// Shared IF-stage definitions: fetch sequencer states, instruction size, boot vector.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fs_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;
  localparam logic [31:0] BOOT_PC    = 32'h0;

  // Redirect targets are word addresses; the low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles an instruction fetch waits for its ack and raises a sticky
// timeout flag once the wait reaches WAIT_LIMIT.
module fetch_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ack_i,
  output logic fetch_err_o
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (req_i && ack_i) begin
      cnt_d = '0;
    end else if (req_i) begin
      // Saturate so a long outage cannot wrap back below the limit.
      if (cnt_q != LIMIT) cnt_d = cnt_q + 8'd1;
      if (cnt_q + 8'd1 >= LIMIT) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err_o = err_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: drives the PC register and the instruction-memory
// handshake, merging EX redirects with ID stalls (redirect > stall > sequential).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        bubbleF,
  output logic        flushF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        flushD,
  output logic        fetch_err
);

  fs_state_t   state_q, state_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] tgt;

  assign tgt = align_word(redirect_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_BOOT;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    pend_d      = pend_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_FETCH;
      FS_FETCH: begin
        // An unacked request cannot be cancelled, so park the target until it drains.
        if (redirect_valid) begin
          if (!imem_ack) begin
            pend_d  = tgt;
            state_d = FS_DRAIN;
          end
        end else if (imem_ack && stall_id) begin
          hold_inst_d = imem_rdata;
          hold_pc_d   = pc;
          state_d     = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (redirect_valid || !stall_id) state_d = FS_FETCH;
      end
      FS_DRAIN: begin
        if (redirect_valid) pend_d = tgt;
        if (imem_ack) state_d = FS_FETCH;
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_comb begin
    npc        = pc;
    bubbleF    = 1'b1;
    flushF     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc;
    inst_valid = 1'b0;
    inst       = hold_inst_q;
    inst_pc    = hold_pc_q;
    flushD     = redirect_valid;
    if (!rst_n) begin
      npc    = BOOT_PC;
      flushD = 1'b0;
    end else begin
      unique case (state_q)
        FS_BOOT: begin
          flushF  = 1'b1;
          bubbleF = 1'b0;
          npc     = BOOT_PC;
        end
        FS_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (redirect_valid) begin
              npc     = tgt;
              bubbleF = 1'b0;
            end else begin
              inst_valid = 1'b1;
              inst       = imem_rdata;
              inst_pc    = pc;
              if (!stall_id) begin
                npc     = pc + INST_BYTES;
                bubbleF = 1'b0;
              end
            end
          end
        end
        FS_HOLD: begin
          if (redirect_valid) begin
            npc     = tgt;
            bubbleF = 1'b0;
          end else begin
            inst_valid = 1'b1;
            if (!stall_id) begin
              npc     = pc + INST_BYTES;
              bubbleF = 1'b0;
            end
          end
        end
        FS_DRAIN: begin
          imem_req = 1'b1;
          // A redirect coinciding with the draining ack is the newest target.
          if (imem_ack) begin
            npc     = redirect_valid ? tgt : pend_q;
            bubbleF = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  fetch_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (imem_req),
    .ack_i      (imem_ack),
    .fetch_err_o(fetch_err)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table, hand-written reset/timeout sequences and a randomized
// run against a queue-based reference model of the fetch sequencer.
module tb_fetch_sequencer;

  localparam int WL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] npc;
  logic        bubbleF, flushF, imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        flushD, fetch_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .npc(npc), .bubbleF(bubbleF), .flushF(flushF),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .flushD(flushD), .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] pc; logic ack; logic [31:0] rdata; logic stall; logic redir; logic [31:0] tgt;
  } in_t;
  typedef struct packed {
    logic req; logic [31:0] addr; logic bub; logic flf; logic [31:0] npc;
    logic iv; logic [31:0] inst; logic [31:0] ipc; logic fld; logic err;
  } out_t;
  typedef struct packed { in_t i; out_t e; } vec_t;

  int total = 0;
  int bad = 0;
  vec_t tbl [23];

  // Reference model state
  logic        m_boot;
  logic [31:0] m_pc;
  logic [31:0] hold_w[$];
  logic [31:0] hold_pc[$];
  logic [31:0] pend[$];
  int          m_wait;
  logic        m_err;

  function automatic vec_t mk(input logic [31:0] p, input logic a, input logic [31:0] rd,
                              input logic s, input logic r, input logic [31:0] t,
                              input logic req, input logic bub, input logic flf,
                              input logic [31:0] np, input logic iv, input logic [31:0] in,
                              input logic fld);
    vec_t v;
    v.i = '{pc:p, ack:a, rdata:rd, stall:s, redir:r, tgt:t};
    v.e = '{req:req, addr:p, bub:bub, flf:flf, npc:np, iv:iv, inst:in, ipc:p, fld:fld, err:1'b0};
    return v;
  endfunction

  task automatic drive(input in_t x);
    pc = x.pc; imem_ack = x.ack; imem_rdata = x.rdata;
    stall_id = x.stall; redirect_valid = x.redir; redirect_target = x.tgt;
  endtask

  task automatic check(input string tag, input out_t e);
    logic ok;
    ok = (imem_req === e.req) && (bubbleF === e.bub) && (flushF === e.flf) &&
         (inst_valid === e.iv) && (flushD === e.fld) && (fetch_err === e.err);
    if (e.req && imem_addr !== e.addr) ok = 1'b0;
    if (!e.bub && npc !== e.npc) ok = 1'b0;
    if (e.iv && (inst !== e.inst || inst_pc !== e.ipc)) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h bub=%b flF=%b npc=%h iv=%b inst=%h ipc=%h flD=%b err=%b | want req=%b addr=%h bub=%b flF=%b npc=%h iv=%b inst=%h ipc=%h flD=%b err=%b",
               tag, imem_req, imem_addr, bubbleF, flushF, npc, inst_valid, inst, inst_pc, flushD, fetch_err,
               e.req, e.addr, e.bub, e.flf, e.npc, e.iv, e.inst, e.ipc, e.fld, e.err);
    end else begin
      $display("ok   %s: req=%b addr=%h bub=%b npc=%h iv=%b inst=%h", tag, imem_req, imem_addr, bubbleF, npc, inst_valid, inst);
    end
  endtask

  task automatic chk_reset(input string tag);
    total++;
    if (imem_req !== 1'b0 || bubbleF !== 1'b1 || flushF !== 1'b0 || npc !== 32'h0 ||
        inst_valid !== 1'b0 || flushD !== 1'b0 || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: got req=%b bub=%b flF=%b npc=%h iv=%b flD=%b err=%b | want req=0 bub=1 flF=0 npc=0 iv=0 flD=0 err=0",
               tag, imem_req, bubbleF, flushF, npc, inst_valid, flushD, fetch_err);
    end else begin
      $display("ok   %s: reset outputs", tag);
    end
  endtask

  // Entered and left at posedge+1; the cycle after release is the boot cycle.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    drive('{pc:32'h0, ack:1'b0, rdata:32'h0, stall:1'b0, redir:1'b0, tgt:32'h0});
    @(negedge clk);
    chk_reset(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input string tag, input in_t x, input out_t e);
    drive(x);
    @(negedge clk);
    check(tag, e);
    @(posedge clk); #1;
  endtask

  task automatic model_reset(input logic [31:0] start_pc);
    m_boot = 1'b1; m_pc = start_pc; m_wait = 0; m_err = 1'b0;
    hold_w.delete(); hold_pc.delete(); pend.delete();
  endtask

  // One cycle of the fetch rules: what the controller must present for these inputs.
  task automatic model_step(input in_t x, output out_t e);
    logic [31:0] t;
    t = x.tgt & ~32'h3;
    e = '{req:1'b0, addr:x.pc, bub:1'b1, flf:1'b0, npc:x.pc, iv:1'b0, inst:32'h0, ipc:32'h0,
          fld:x.redir, err:m_err};
    if (m_boot) begin
      e.flf = 1'b1; e.bub = 1'b0; e.npc = 32'h0; m_boot = 1'b0;
    end else if (hold_w.size() != 0) begin
      if (x.redir) begin
        e.npc = t; e.bub = 1'b0; hold_w.delete(); hold_pc.delete();
      end else begin
        e.iv = 1'b1; e.inst = hold_w[0]; e.ipc = hold_pc[0];
        if (!x.stall) begin
          e.npc = x.pc + 32'd4; e.bub = 1'b0; hold_w.delete(); hold_pc.delete();
        end
      end
    end else begin
      e.req = 1'b1;
      if (pend.size() != 0) begin
        if (x.redir) pend[0] = t;
        if (x.ack) begin
          e.npc = pend[0]; e.bub = 1'b0; pend.delete();
        end
      end else if (x.ack) begin
        if (x.redir) begin
          e.npc = t; e.bub = 1'b0;
        end else begin
          e.iv = 1'b1; e.inst = x.rdata; e.ipc = x.pc;
          if (x.stall) begin
            hold_w.push_back(x.rdata); hold_pc.push_back(x.pc);
          end else begin
            e.npc = x.pc + 32'd4; e.bub = 1'b0;
          end
        end
      end else if (x.redir) begin
        pend.push_back(t);
      end
    end
    if (e.req && x.ack) m_wait = 0;
    else if (e.req) begin
      m_wait++;
      if (m_wait >= WL) m_err = 1'b1;
    end
    m_pc = e.flf ? 32'h0 : (e.bub ? x.pc : e.npc);
  endtask

  initial begin
    in_t  x;
    out_t e;
    int   outage;

    tbl[0]  = mk(32'hDEADBEE0, 0, 0, 0, 0, 0,             0, 0, 1, 32'h0,   0, 0, 0);
    tbl[1]  = mk(32'h0,  1, 32'h1000_0000, 0, 0, 0,        1, 0, 0, 32'h4,   1, 32'h1000_0000, 0);
    tbl[2]  = mk(32'h4,  1, 32'h1000_0001, 0, 0, 0,        1, 0, 0, 32'h8,   1, 32'h1000_0001, 0);
    tbl[3]  = mk(32'h8,  1, 32'h1000_0002, 0, 0, 0,        1, 0, 0, 32'hC,   1, 32'h1000_0002, 0);
    tbl[4]  = mk(32'hC,  0, 0, 0, 0, 0,                    1, 1, 0, 32'h0,   0, 0, 0);
    tbl[5]  = mk(32'hC,  0, 0, 0, 0, 0,                    1, 1, 0, 32'h0,   0, 0, 0);
    tbl[6]  = mk(32'hC,  0, 0, 0, 0, 0,                    1, 1, 0, 32'h0,   0, 0, 0);
    tbl[7]  = mk(32'hC,  1, 32'h1000_0003, 0, 0, 0,        1, 0, 0, 32'h10,  1, 32'h1000_0003, 0);
    tbl[8]  = mk(32'h10, 1, 32'h0050_0093, 1, 0, 0,        1, 1, 0, 32'h0,   1, 32'h0050_0093, 0);
    tbl[9]  = mk(32'h10, 0, 0, 1, 0, 0,                    0, 1, 0, 32'h0,   1, 32'h0050_0093, 0);
    tbl[10] = mk(32'h10, 0, 0, 0, 0, 0,                    0, 0, 0, 32'h14,  1, 32'h0050_0093, 0);
    tbl[11] = mk(32'h14, 1, 32'h1000_0005, 0, 0, 0,        1, 0, 0, 32'h18,  1, 32'h1000_0005, 0);
    tbl[12] = mk(32'h18, 1, 32'h1000_0006, 0, 1, 32'h40,   1, 0, 0, 32'h40,  0, 0, 1);
    tbl[13] = mk(32'h40, 0, 0, 0, 1, 32'h200,              1, 1, 0, 32'h0,   0, 0, 1);
    tbl[14] = mk(32'h40, 0, 0, 0, 0, 0,                    1, 1, 0, 32'h0,   0, 0, 0);
    tbl[15] = mk(32'h40, 1, 32'hBAD0_0040, 0, 0, 0,        1, 0, 0, 32'h200, 0, 0, 0);
    tbl[16] = mk(32'h200, 0, 0, 0, 1, 32'h100,             1, 1, 0, 32'h0,   0, 0, 1);
    tbl[17] = mk(32'h200, 0, 0, 0, 1, 32'h300,             1, 1, 0, 32'h0,   0, 0, 1);
    tbl[18] = mk(32'h200, 1, 32'hBAD0_0200, 0, 0, 0,       1, 0, 0, 32'h300, 0, 0, 0);
    tbl[19] = mk(32'h300, 1, 32'h1000_0007, 0, 1, 32'h303, 1, 0, 0, 32'h300, 0, 0, 1);
    tbl[20] = mk(32'h300, 1, 32'h1000_0008, 1, 0, 0,       1, 1, 0, 32'h0,   1, 32'h1000_0008, 0);
    tbl[21] = mk(32'h300, 0, 0, 1, 1, 32'h44,              0, 0, 0, 32'h44,  0, 0, 1);
    tbl[22] = mk(32'h44, 1, 32'h1000_0009, 0, 0, 0,       1, 0, 0, 32'h48,  1, 32'h1000_0009, 0);

    @(posedge clk); #1;
    do_reset("reset0");
    for (int k = 0; k < 23; k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Timeout: WL unacked cycles, flag visible on the next cycle, sticky after ack.
    x = '{pc:32'h48, ack:1'b0, rdata:32'h0, stall:1'b0, redir:1'b0, tgt:32'h0};
    e = '{req:1'b1, addr:32'h48, bub:1'b1, flf:1'b0, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b0};
    for (int k = 1; k <= WL; k++) step($sformatf("wait%0d", k), x, e);
    e.err = 1'b1;
    step("err_set", x, e);
    x.ack = 1'b1; x.rdata = 32'h2000_0048;
    e = '{req:1'b1, addr:32'h48, bub:1'b0, flf:1'b0, npc:32'h4C, iv:1'b1, inst:32'h2000_0048, ipc:32'h48, fld:1'b0, err:1'b1};
    step("err_ack", x, e);
    x = '{pc:32'h4C, ack:1'b0, rdata:32'h0, stall:1'b0, redir:1'b0, tgt:32'h0};
    e = '{req:1'b1, addr:32'h4C, bub:1'b1, flf:1'b0, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b1};
    step("err_sticky", x, e);
    do_reset("err_clear");

    // Reset mid-fetch, then a late ack during boot must be ignored.
    e = '{req:1'b0, addr:32'h0, bub:1'b0, flf:1'b1, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b0};
    step("boot1", x, e);
    x.pc = 32'h0;
    e = '{req:1'b1, addr:32'h0, bub:1'b1, flf:1'b0, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b0};
    step("fetch0", x, e);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    x = '{pc:32'h0, ack:1'b1, rdata:32'hBAD0_BAD0, stall:1'b0, redir:1'b0, tgt:32'h0};
    e = '{req:1'b0, addr:32'h0, bub:1'b0, flf:1'b1, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b0};
    step("late_ack", x, e);
    x.ack = 1'b0;
    e = '{req:1'b1, addr:32'h0, bub:1'b1, flf:1'b0, npc:32'h0, iv:1'b0, inst:32'h0, ipc:32'h0, fld:1'b0, err:1'b0};
    step("refetch0", x, e);

    // Randomized traffic against the reference model.
    outage = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 0) begin
        do_reset($sformatf("rreset%0d", n));
        model_reset($urandom);
      end
      x.pc    = m_pc;
      x.ack   = 1'b0;
      if (!m_boot && hold_w.size() == 0) begin
        if (outage > 0) outage--;
        else if ($urandom_range(0, 149) == 0) outage = WL + 1;
        else x.ack = ($urandom_range(0, 3) != 0);
      end
      x.rdata = $urandom;
      x.stall = ($urandom_range(0, 2) == 0);
      x.redir = ($urandom_range(0, 7) == 0);
      x.tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      model_step(x, e);
      step($sformatf("rand%0d", n), x, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
